// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Boot-time loader for a 16 x 16-bit instruction RAM. Program bytes arrive on
//   data_in, each marked by a rising edge of the asynchronous pad strobe
//   data_strobe. Bytes pair up low-then-high into words that are written to
//   consecutive RAM addresses. The CPU is held in reset while a load runs.
//
// Configuration:
//   LOADER_CHECKSUM_EN  defined   -> a 33rd trailer byte is compared against the
//                                    XOR of the 32 program bytes, and chk_err
//                                    reports a mismatch (CPU stays held).
//                       undefined -> no trailer byte; chk_err is tied to 0.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset (also zeroes the RAM)
//   load_en      level request for a load session (synchronous to clk)
//   data_in      [7:0] program byte, stable around the strobe rise
//   data_strobe  asynchronous byte strobe from the pad
//   rd_addr      [3:0] CPU fetch word index
//   rd_data      [15:0] RAM word at rd_addr (combinational)
//   cpu_hold     keeps the CPU in reset while high
//   busy         session in progress (LO_BYTE / HI_BYTE / CHECK)
//   word_count   [4:0] words written in the current session, 0..16
//   done         session completed
//   chk_err      trailer checksum mismatch
// -----------------------------------------------------------------------------
module imem_loader (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_en,
  input  logic [7:0]  data_in,
  input  logic        data_strobe,
  input  logic [3:0]  rd_addr,
  output logic [15:0] rd_data,
  output logic        cpu_hold,
  output logic        busy,
  output logic [4:0]  word_count,
  output logic        done,
  output logic        chk_err
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LO_BYTE = 3'd1;
  localparam logic [2:0] ST_HI_BYTE = 3'd2;
  localparam logic [2:0] ST_CHECK   = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  logic [2:0]  r_state;
  logic [3:0]  r_addr;
  logic [7:0]  r_lo;
  logic [4:0]  r_word_count;
  logic        r_hold_rst;
  logic [15:0] r_mem [16];

  logic        r_strb_meta;
  logic        r_strb_sync;
  logic        r_strb_prev;
  logic        w_pulse;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  r_csum;
  logic        r_chk_err;
`endif

  // Two-flop synchronizer plus edge detector: one-cycle pulse per pad rise,
  // so a strobe held high for many cycles still yields exactly one byte.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours, exactly like the hardware.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_strb_meta <= 1'b0;
      r_strb_sync <= 1'b0;
      r_strb_prev <= 1'b0;
    end else begin
      r_strb_meta <= data_strobe;
      r_strb_sync <= r_strb_meta;
      r_strb_prev <= r_strb_sync;
    end
  end

  assign w_pulse = r_strb_sync & ~r_strb_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_addr       <= 4'd0;
      r_lo         <= 8'd0;
      r_word_count <= 5'd0;
      r_hold_rst   <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
      r_csum       <= 8'd0;
      r_chk_err    <= 1'b0;
`endif
      // NOTE: the RAM is deliberately reset so a reset mid-load never leaves a
      // half-written program fetchable; it is therefore built from flops.
      for (int i = 0; i < 16; i++) r_mem[i] <= 16'h0000;
    end else begin
      // Reset-time hold is released on the first edge; afterwards cpu_hold
      // follows the FSM alone.
      r_hold_rst <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (load_en) begin
            r_state      <= ST_LO_BYTE;
            r_addr       <= 4'd0;
            r_word_count <= 5'd0;
`ifdef LOADER_CHECKSUM_EN
            r_csum       <= 8'd0;
            r_chk_err    <= 1'b0;
`endif
          end
        end
        // In every busy state a dropped load_en wins over a same-cycle pulse.
        ST_LO_BYTE: begin
          if (!load_en) begin
            r_state <= ST_IDLE;
          end else if (w_pulse) begin
            r_lo    <= data_in;
`ifdef LOADER_CHECKSUM_EN
            r_csum  <= r_csum ^ data_in;
`endif
            r_state <= ST_HI_BYTE;
          end
        end
        ST_HI_BYTE: begin
          if (!load_en) begin
            r_state <= ST_IDLE;
          end else if (w_pulse) begin
            r_mem[r_addr] <= {data_in, r_lo};
            r_word_count  <= r_word_count + 5'd1;
`ifdef LOADER_CHECKSUM_EN
            r_csum        <= r_csum ^ data_in;
`endif
            // Address stops at 15: the session ends instead of wrapping.
            if (r_addr == 4'd15) begin
`ifdef LOADER_CHECKSUM_EN
              r_state <= ST_CHECK;
`else
              r_state <= ST_DONE;
`endif
            end else begin
              r_addr  <= r_addr + 4'd1;
              r_state <= ST_LO_BYTE;
            end
          end
        end
        ST_CHECK: begin
          if (!load_en) begin
            r_state <= ST_IDLE;
          end else if (w_pulse) begin
`ifdef LOADER_CHECKSUM_EN
            r_chk_err <= (data_in != r_csum);
`endif
            r_state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!load_en) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  assign chk_err = r_chk_err;
`else
  assign chk_err = 1'b0;
`endif

  assign rd_data    = r_mem[rd_addr];
  assign word_count = r_word_count;
  assign busy       = (r_state == ST_LO_BYTE) || (r_state == ST_HI_BYTE) ||
                      (r_state == ST_CHECK);
  assign done       = (r_state == ST_DONE);
  assign cpu_hold   = r_hold_rst | busy | (done & chk_err);

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//   Scoreboard bench for imem_loader. The stimulus thread pushes expected
//   observations into exp_q and raises req; the monitor pops and compares them
//   on the falling edge. A second scoreboard (wc_q) holds the expected
//   word_count after every write the stimulus intends; the monitor pops it each
//   time word_count rises, so any unexpected write is also caught.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_en = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic        data_strobe = 1'b0;
  logic [3:0]  rd_addr = 4'd0;
  logic [15:0] rd_data;
  logic        cpu_hold;
  logic        busy;
  logic [4:0]  word_count;
  logic        done;
  logic        chk_err;

  imem_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_en     (load_en),
    .data_in     (data_in),
    .data_strobe (data_strobe),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .cpu_hold    (cpu_hold),
    .busy        (busy),
    .word_count  (word_count),
    .done        (done),
    .chk_err     (chk_err)
  );

  always #5 clk = ~clk;

  typedef enum {OBS_RD, OBS_HOLD, OBS_BUSY, OBS_DONE, OBS_WC, OBS_ERR} obs_e;
  typedef struct {
    string       name;
    obs_e        obs;
    logic [15:0] exp;
  } exp_t;

  exp_t        exp_q[$];
  int          wc_q[$];
  logic        req = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          tb_wc = 0;
  logic [7:0]  tb_xor = 8'h00;
  logic [4:0]  wc_prev = 5'd0;
  exp_t        mon_e;

  // Program image, hand-written; sent low byte first.
  logic [15:0] words [16] = '{16'h0123, 16'h1234, 16'h2345, 16'h3456,
                              16'h4567, 16'h5678, 16'h6789, 16'h789A,
                              16'h89AB, 16'h9ABC, 16'hABCD, 16'hBCDE,
                              16'hCDEF, 16'hDEF0, 16'hEF01, 16'hF012};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] observe(input obs_e o);
    case (o)
      OBS_RD:   return rd_data;
      OBS_HOLD: return {15'd0, cpu_hold};
      OBS_BUSY: return {15'd0, busy};
      OBS_DONE: return {15'd0, done};
      OBS_WC:   return {11'd0, word_count};
      OBS_ERR:  return {15'd0, chk_err};
      default:  return 16'hxxxx;
    endcase
  endfunction

  // Monitor: compares on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (req) begin
      while (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check(mon_e.name, {16'd0, observe(mon_e.obs)}, {16'd0, mon_e.exp});
      end
    end
    if (word_count > wc_prev) begin
      if (wc_q.size() == 0) check("unexpected_write", {27'd0, word_count}, {27'd0, wc_prev});
      else                  check("word_count_step", {27'd0, word_count}, wc_q.pop_front());
    end
    wc_prev = word_count;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_obs(input string name, input obs_e o, input logic [15:0] v);
    exp_t e;
    e.name = name;
    e.obs  = o;
    e.exp  = v;
    exp_q.push_back(e);
  endtask

  // Hand the pending expectations to the monitor, then realign to posedge+1.
  task automatic sample();
    req = 1'b1;
    @(negedge clk);
    #1;
    req = 1'b0;
    tick(1);
  endtask

  task automatic check_word(input string name, input logic [3:0] a, input logic [15:0] v);
    rd_addr = a;
    expect_obs(name, OBS_RD, v);
    sample();
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    data_in = b;
    tick(1);
    data_strobe = 1'b1;
    tick(hold);
    data_strobe = 1'b0;
    tick(3);
  endtask

  task automatic send_word(input logic [15:0] w);
    send_byte(w[7:0], 4);
    tb_wc++;
    wc_q.push_back(tb_wc);
    send_byte(w[15:8], 4);
    tb_xor = tb_xor ^ w[7:0] ^ w[15:8];
  endtask

  task automatic start_session();
    load_en = 1'b1;
    tick(1);
    tb_wc  = 0;
    tb_xor = 8'h00;
  endtask

  initial begin
    // Reset state, held for 3 cycles.
    tick(3);
    expect_obs("rst_hold", OBS_HOLD, 16'd1);
    expect_obs("rst_busy", OBS_BUSY, 16'd0);
    expect_obs("rst_done", OBS_DONE, 16'd0);
    expect_obs("rst_wc",   OBS_WC,   16'd0);
    expect_obs("rst_err",  OBS_ERR,  16'd0);
    sample();
    check_word("rst_ram0",  4'd0,  16'h0000);
    check_word("rst_ram15", 4'd15, 16'h0000);
    rst_n = 1'b1;
    tick(1);
    expect_obs("post_rst_hold", OBS_HOLD, 16'd0);
    expect_obs("post_rst_busy", OBS_BUSY, 16'd0);
    sample();

    // Full load of 16 words.
    start_session();
    expect_obs("start_busy", OBS_BUSY, 16'd1);
    expect_obs("start_hold", OBS_HOLD, 16'd1);
    expect_obs("start_wc",   OBS_WC,   16'd0);
    sample();
    for (int i = 0; i < 16; i++) send_word(words[i]);
`ifdef LOADER_CHECKSUM_EN
    expect_obs("check_busy", OBS_BUSY, 16'd1);
    expect_obs("check_done", OBS_DONE, 16'd0);
    sample();
    send_byte(tb_xor, 4);
    expect_obs("good_sum_err",  OBS_ERR,  16'd0);
    expect_obs("good_sum_hold", OBS_HOLD, 16'd0);
`endif
    expect_obs("full_done", OBS_DONE, 16'd1);
    expect_obs("full_busy", OBS_BUSY, 16'd0);
    expect_obs("full_hold", OBS_HOLD, 16'd0);
    expect_obs("full_wc",   OBS_WC,   16'd16);
    expect_obs("full_err",  OBS_ERR,  16'd0);
    sample();
    check_word("full_ram0",  4'd0,  16'h0123);
    check_word("full_ram7",  4'd7,  16'h789A);
    check_word("full_ram15", 4'd15, 16'hF012);

    // Strobes in DONE are ignored.
    send_byte(8'hAA, 4);
    send_byte(8'hBB, 4);
    expect_obs("done_ign_wc",   OBS_WC,   16'd16);
    expect_obs("done_ign_done", OBS_DONE, 16'd1);
    sample();
    check_word("done_ign_ram0", 4'd0, 16'h0123);

`ifdef LOADER_CHECKSUM_EN
    // Same load with a corrupted trailer.
    load_en = 1'b0;
    tick(1);
    start_session();
    for (int i = 0; i < 16; i++) send_word(words[i]);
    send_byte(tb_xor ^ 8'h01, 4);
    expect_obs("bad_sum_err",  OBS_ERR,  16'd1);
    expect_obs("bad_sum_hold", OBS_HOLD, 16'd1);
    expect_obs("bad_sum_done", OBS_DONE, 16'd1);
    sample();
`endif

    // Back to IDLE; strobes there are ignored.
    load_en = 1'b0;
    tick(1);
    expect_obs("idle_done", OBS_DONE, 16'd0);
    expect_obs("idle_hold", OBS_HOLD, 16'd0);
    sample();
    send_byte(8'h55, 4);
    send_byte(8'h66, 4);
    expect_obs("idle_ign_wc", OBS_WC, 16'd16);
    sample();
    check_word("idle_ign_ram0", 4'd0, 16'h0123);

    // Abort after 5 bytes.
    start_session();
    send_word(16'hBEEF);
    send_word(16'hCAFE);
    send_byte(8'h77, 4);
    load_en = 1'b0;
    tick(1);
    expect_obs("abort_busy", OBS_BUSY, 16'd0);
    expect_obs("abort_done", OBS_DONE, 16'd0);
    expect_obs("abort_wc",   OBS_WC,   16'd2);
    expect_obs("abort_hold", OBS_HOLD, 16'd0);
    sample();
    check_word("abort_ram0", 4'd0, 16'hBEEF);
    check_word("abort_ram1", 4'd1, 16'hCAFE);
    check_word("abort_ram2", 4'd2, 16'h2345);

    // A strobe held high for 10 cycles is one byte.
    start_session();
    send_byte(8'h11, 10);
    tb_wc++;
    wc_q.push_back(tb_wc);
    send_byte(8'h22, 4);
    expect_obs("glitch_wc",   OBS_WC,   16'd1);
    expect_obs("glitch_busy", OBS_BUSY, 16'd1);
    sample();
    check_word("glitch_ram0", 4'd0, 16'h2211);
    check_word("glitch_ram1", 4'd1, 16'hCAFE);

    // Reset mid-session discards everything.
    rst_n = 1'b0;
    load_en = 1'b0;
    tick(1);
    expect_obs("midrst_wc",   OBS_WC,   16'd0);
    expect_obs("midrst_busy", OBS_BUSY, 16'd0);
    expect_obs("midrst_hold", OBS_HOLD, 16'd1);
    sample();
    check_word("midrst_ram0", 4'd0, 16'h0000);
    check_word("midrst_ram1", 4'd1, 16'h0000);
    rst_n = 1'b1;
    tick(1);
    expect_obs("midrst_release_hold", OBS_HOLD, 16'd0);
    sample();

    // Bounded drain of both scoreboards.
    for (int i = 0; i < 20 && (exp_q.size() + wc_q.size()) > 0; i++) tick(1);
    check("scoreboard_drained", exp_q.size() + wc_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-002 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: load_en  input  1  load-session request, level; synchronous to clk.
REQ-004 SHALL have port: data_in  input  8  program byte; stable from 1 cycle before the strobe rise to 3 cycles after it.
REQ-005 SHALL have port: data_strobe  input  1  byte strobe from pad, asynchronous; a rising edge marks a new byte.
REQ-006 SHALL have port: rd_addr  input  4  CPU fetch word index (PC>>1).
REQ-007 SHALL have port: rd_data  output  16  program word at rd_addr, combinational read.
REQ-008 SHALL have port: cpu_hold  output  1  keeps the CPU in reset while high.
REQ-009 SHALL have port: busy  output  1  high in LO_BYTE, HI_BYTE, CHECK.
REQ-010 SHALL have port: word_count  output  5  words written in the current session, 0..16.
REQ-011 SHALL have port: done  output  1  high in DONE.
REQ-012 SHALL have port: chk_err  output  1  checksum mismatch flag.

Function
REQ-013 SHALL hold a 16 x 16-bit program RAM, written only by this block and read through rd_addr/rd_data.
REQ-014 SHALL pass data_strobe through a 2-flop synchronizer and a rising-edge detector, giving a 1-cycle pulse 2-3 cycles after the pad edge.
REQ-015 SHALL sample data_in in the cycle the pulse is high.
REQ-016 SHALL implement FSM states IDLE, LO_BYTE, HI_BYTE, CHECK, DONE.
REQ-017 IDLE: load_en=1 -> LO_BYTE; address, word_count, checksum and chk_err cleared in the same edge.
REQ-018 LO_BYTE: on a pulse, latch the byte as the low half -> HI_BYTE.
REQ-019 HI_BYTE: on a pulse, write {byte, low half} to RAM[addr] and increment addr and word_count; addr=15 -> CHECK (macro on) or DONE (macro off), otherwise -> LO_BYTE.
REQ-020 A RAM write SHALL be visible on rd_data in the cycle after the writing edge.
REQ-021 DONE: load_en=0 -> IDLE; a new session needs load_en low then high again.
REQ-022 load_en=0 in LO_BYTE, HI_BYTE or CHECK SHALL abort to IDLE and takes priority over a same-cycle pulse (no write). Words already written are retained and word_count holds its value.
REQ-023 Pulses in IDLE and DONE SHALL be ignored.
REQ-024 cpu_hold SHALL be 1 when busy, and 1 in DONE while chk_err=1; otherwise 0.
REQ-025 The address SHALL never wrap inside a session; a 17th word is impossible because DONE ignores strobes.

Reset
REQ-026 rst_n low SHALL asynchronously force:
- FSM to IDLE
- all RAM words, address, low-byte latch and checksum to 0x0000/0
- word_count=0, busy=0, done=0, chk_err=0, cpu_hold=1
- synchronizer flops to 0
REQ-027 cpu_hold SHALL deassert on the first clock edge after rst_n rises if the FSM is in IDLE.
REQ-028 Reset mid-session SHALL discard the partial session, with RAM zeroed per REQ-026.

Configuration
REQ-029 Macro LOADER_CHECKSUM_EN:
- Defined: an 8-bit running XOR of all 32 data bytes SHALL be kept. CHECK consumes one more byte and -> DONE; chk_err is set if that byte differs from the XOR.
- Undefined: CHECK is unreachable and chk_err SHALL be constant 0.

Verification
REQ-030 Reset: rst_n=0 for 3 cycles -> rd_data=0x0000 for all rd_addr, cpu_hold=1; after release, cpu_hold=0, state IDLE.
REQ-031 Full load (macro off): load_en=1, then bytes 0x23,0x01 ... (32 bytes) -> RAM[0]=0x0123, word_count=16, done=1, cpu_hold=0.
REQ-032 Checksum (macro on): 32 bytes, then a trailer equal to their XOR -> chk_err=0, cpu_hold=0; same load with trailer XOR^0x01 -> chk_err=1, cpu_hold stays 1.
REQ-033 Abort: load_en dropped after 5 bytes -> IDLE, RAM[0..1] written, RAM[2] unchanged, word_count=2, done=0.
REQ-034 Glitch/ignore: strobe held high 10 cycles gives exactly one byte; strobes in IDLE/DONE leave RAM and word_count unchanged.
